btn_tick_debouncer: RTL and testbench
=====================================

Name: btn_tick_debouncer

Overview:
- Receiving end of the slow divided-clock interface: consumes the slow square wave generated from the 25 MHz system clock.
- Re-times that wave into the system clock domain as a one-cycle sample tick.
- Uses each tick to sample and debounce the keypad/push-button inputs of the lock.
- Emits clean level, press-pulse and release-pulse signals to the lock FSM.

Parameters:
- N_BUTTONS, 4, number of independent button inputs debounced.
- STABLE_SAMPLES, 3, consecutive tick samples of one value required to accept a level change (legal range 1..15).
- CNT_W, 4, width of the per-button stability counter; must hold STABLE_SAMPLES.

Ports:
- clk_in  input  1  system clock, 25 MHz.
- rst  input  1  asynchronous, active-high reset.
- divided_clk  input  1  slow square wave from the clock divider; asynchronous to this block's sampling logic.
- btn_raw  input  N_BUTTONS  raw, bouncing, asynchronous buttons; 1 = pressed.
- sample_tick  output  1  one-cycle pulse per divided_clk rising edge.
- btn_level  output  N_BUTTONS  debounced stable level.
- btn_press  output  N_BUTTONS  one-cycle pulse on accepted 0->1.
- btn_release  output  N_BUTTONS  one-cycle pulse on accepted 1->0.
- any_press  output  1  OR of btn_press, same cycle.

Behaviour:
- Clocking and reset:
  - Single clock clk_in. All flops reset asynchronously on rst=1.
  - Reset values: sample_tick=0, btn_level=0, btn_press=0, btn_release=0, any_press=0. All sync/edge flops, counters and FSMs clear.
- Tick generation:
  - divided_clk passes through a 2-flop synchronizer, then a previous-value flop.
  - sample_tick=1 for exactly one clk_in cycle when synced=1 and prev=0.
  - Latency: tick asserts 3 clk_in cycles after divided_clk rises.
  - Falling edges produce nothing.
  - divided_clk already high at reset release yields one tick 3 cycles later. This is accepted behaviour.
- Button path:
  - Each btn_raw bit passes through its own 2-flop synchronizer.
  - Buttons are sampled only on cycles where sample_tick=1. Between ticks, all debounce state holds.
- Per-button FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus counter cnt[CNT_W-1:0]:
  - IDLE: on tick with sample=1, cnt<=1 and go to PRESS_WAIT. If STABLE_SAMPLES=1, go directly to PRESSED and fire press.
  - PRESS_WAIT:
    - Tick with sample=1: cnt<=cnt+1. When cnt+1==STABLE_SAMPLES, go to PRESSED, cnt<=0, fire press.
    - Tick with sample=0: go to IDLE, cnt<=0.
  - PRESSED: symmetric to IDLE with sample=0, moving to RELEASE_WAIT.
  - RELEASE_WAIT: symmetric to PRESS_WAIT. Completion goes to IDLE and fires release; a sample=1 returns to PRESSED.
- Outputs:
  - btn_level=1 in PRESSED and RELEASE_WAIT, 0 otherwise.
  - btn_press and btn_release are registered and asserted for one clk_in cycle, the cycle after the accepting tick.
- Latency: a clean press is reported STABLE_SAMPLES ticks after the first high sample.
- Boundaries:
  - Any disagreeing sample restarts qualification; no partial credit.
  - cnt never exceeds STABLE_SAMPLES and never wraps.
  - Buttons are fully independent. Simultaneous presses give simultaneous pulses, and any_press is asserted once for that cycle.
  - Reset mid-qualification or while pressed returns to IDLE with no pulse emitted.
  - A pulse never coincides with reset deassertion.

Decomposition:
- Shared package lock_pkg:
  - FSM state localparams: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - Default STABLE_SAMPLES.
  - N_BUTTONS default for the keypad.
- Sub-module debounce_cell: one synchronized button bit, sample_tick in; level/press/release out. Instantiated N_BUTTONS times via generate.
- Tick edge detector and button synchronizers stay in the top.

Test Plan:
- Bench setup: clk_in 40 ns period. divided_clk driven by the bench with a 20-cycle period (10 high/10 low) for speed.
- Reset then idle: rst=1 for 5 cycles with divided_clk=0 -> all outputs 0; sample_tick pulses 1 cycle wide, 20 cycles apart, 3 cycles after each rise.
- Clean press: btn_raw[0]=1 held -> btn_press[0] pulses once, one cycle after 3rd tick; btn_level[0]=1 thereafter; any_press pulses the same cycle.
- Bounce: btn_raw[1] pattern 1,0,1,1,1 across successive ticks -> no press after tick 2; press one cycle after tick 5; exactly one pulse.
- Release and simultaneity: buttons 0 and 2 rise together, held 5 ticks, then drop together -> press[0] and press[2] pulse in the same cycle; any_press pulses once; release pulses for both on the same cycle after 3 low ticks.
- Reset mid-operation: assert rst after 2 qualifying ticks on btn_raw[3], then release it -> no press pulse; btn_level[3]=0; requalification needs 3 fresh ticks.
- Parameter sweep at STABLE_SAMPLES=1: a single high tick presses immediately; a single low tick releases.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock's button front end.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int unsigned DEF_N_BUTTONS      = 4;
  localparam int unsigned DEF_STABLE_SAMPLES = 3;
  localparam int unsigned DEF_CNT_W          = 4;

endpackage

// File: rtl/debounce_cell.sv
// Debounces one synchronized button bit, advancing only on sample_tick.
// Emits the accepted level plus registered one-cycle press/release pulses.
module debounce_cell
  import lock_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sample_tick,
  input  logic sample,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(STABLE_SAMPLES);
  localparam bit               SINGLE = (STABLE_SAMPLES == 1);

  db_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             cnt_done;
  logic             press_nx, release_nx;

  assign cnt_done = ((cnt + 1'b1) == LAST);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (sample) begin
            if (SINGLE) begin
              state_nx = PRESSED;
              press_nx = 1'b1;
            end else begin
              state_nx = PRESS_WAIT;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt_done) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sample) begin
            if (SINGLE) begin
              state_nx   = IDLE;
              release_nx = 1'b1;
            end else begin
              state_nx = RELEASE_WAIT;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (sample) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt_done) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            release_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
    end
  end

  assign level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/btn_tick_debouncer.sv
// Turns the slow divided clock into a one-cycle sample tick and uses it to
// debounce the lock's buttons into level/press/release signals.
module btn_tick_debouncer
  import lock_pkg::*;
#(
  parameter int unsigned N_BUTTONS      = DEF_N_BUTTONS,
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 divided_clk,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic                 sample_tick,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic                 any_press
);

  logic [1:0]           dclk_sync;
  logic                 dclk_prev;
  logic [N_BUTTONS-1:0] btn_meta, btn_sync;

  // Registered edge detect puts the tick 3 cycles after the divided_clk rise.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dclk_sync   <= '0;
      dclk_prev   <= 1'b0;
      sample_tick <= 1'b0;
      btn_meta    <= '0;
      btn_sync    <= '0;
    end else begin
      dclk_sync   <= {dclk_sync[0], divided_clk};
      dclk_prev   <= dclk_sync[1];
      sample_tick <= dclk_sync[1] & ~dclk_prev;
      btn_meta    <= btn_raw;
      btn_sync    <= btn_meta;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
    debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .CNT_W         (CNT_W)
    ) u_cell (
      .clk_in       (clk_in),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .sample       (btn_sync[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_tick_debouncer.sv
// Bench for btn_tick_debouncer: directed tick-by-tick table, reset corner case
// and randomized buttons against a run-length reference model (SS=3 and SS=1).
module tb_btn_tick_debouncer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       divided_clk = 1'b0;
  logic [3:0] btn_raw = '0;

  logic       tick_a, any_a, tick_b, any_b;
  logic [3:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;

  always #20 clk_in = ~clk_in;

  btn_tick_debouncer #(.N_BUTTONS(4), .STABLE_SAMPLES(3), .CNT_W(4)) u_dut (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .btn_raw(btn_raw),
    .sample_tick(tick_a), .btn_level(lvl_a), .btn_press(prs_a),
    .btn_release(rel_a), .any_press(any_a)
  );

  btn_tick_debouncer #(.N_BUTTONS(4), .STABLE_SAMPLES(1), .CNT_W(4)) u_dut1 (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .btn_raw(btn_raw),
    .sample_tick(tick_b), .btn_level(lvl_b), .btn_press(prs_b),
    .btn_release(rel_b), .any_press(any_b)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lvl;
    int         anyc;
  } vec_t;

  vec_t       tbl[19];
  int         n_cmp = 0;
  int         n_err = 0;
  int         since_rise = 100;
  int         ss[2] = '{3, 1};
  logic [3:0] m_lvl[2];
  logic [3:0] m_prs[2];
  logic [3:0] m_rel[2];
  int         m_run[2][4];
  logic [3:0] acc_prs, acc_rel;
  int         any_cnt, tick_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = '0;
      m_prs[i] = '0;
      m_rel[i] = '0;
      for (int b = 0; b < 4; b++) m_run[i][b] = 0;
    end
    since_rise = 100;
  endtask

  // Called just after a falling clk edge: compare, then advance the model.
  task automatic check_cycle();
    logic exp_tick;
    exp_tick = (since_rise == 3) && !rst;
    chk("tick_a", 32'(tick_a), 32'(exp_tick));
    chk("tick_b", 32'(tick_b), 32'(exp_tick));
    chk("outs_a", 32'({lvl_a, prs_a, rel_a, any_a}),
        32'({m_lvl[0], m_prs[0], m_rel[0], |m_prs[0]}));
    chk("outs_b", 32'({lvl_b, prs_b, rel_b, any_b}),
        32'({m_lvl[1], m_prs[1], m_rel[1], |m_prs[1]}));
    acc_prs  = acc_prs | prs_a;
    acc_rel  = acc_rel | rel_a;
    any_cnt  = any_cnt + int'(any_a);
    tick_cnt = tick_cnt + int'(tick_a);
    for (int i = 0; i < 2; i++) begin
      m_prs[i] = '0;
      m_rel[i] = '0;
      if (exp_tick) begin
        for (int b = 0; b < 4; b++) begin
          if (btn_raw[b] != m_lvl[i][b]) begin
            m_run[i][b]++;
            if (m_run[i][b] == ss[i]) begin
              if (btn_raw[b]) m_prs[i][b] = 1'b1;
              else            m_rel[i][b] = 1'b1;
              m_lvl[i][b] = btn_raw[b];
              m_run[i][b] = 0;
            end
          end else begin
            m_run[i][b] = 0;
          end
        end
      end
    end
  endtask

  task automatic run_cycle(input logic dclk, input logic [3:0] raw);
    if (dclk && !divided_clk) since_rise = 0;
    divided_clk = dclk;
    btn_raw     = raw;
    @(negedge clk_in);
    if (since_rise < 100) since_rise++;
    check_cycle();
  endtask

  task automatic run_period(input logic [3:0] raw);
    acc_prs  = '0;
    acc_rel  = '0;
    any_cnt  = 0;
    tick_cnt = 0;
    for (int p = 0; p < 20; p++) run_cycle(p < 10, raw);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < cycles; c++) run_cycle(1'b0, btn_raw);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] nxt;
    //            raw      press    release  level   any
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[2]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 0};
    tbl[5]  = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 0};
    tbl[6]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[7]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1};
    tbl[8]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0010, 0};
    tbl[9]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0010, 0};
    tbl[10] = '{4'b0111, 4'b0101, 4'b0000, 4'b0111, 1};
    tbl[11] = '{4'b0111, 4'b0000, 4'b0000, 4'b0111, 0};
    tbl[12] = '{4'b0111, 4'b0000, 4'b0000, 4'b0111, 0};
    tbl[13] = '{4'b0010, 4'b0000, 4'b0000, 4'b0111, 0};
    tbl[14] = '{4'b0010, 4'b0000, 4'b0000, 4'b0111, 0};
    tbl[15] = '{4'b0010, 4'b0000, 4'b0101, 4'b0010, 0};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 0};
    tbl[17] = '{4'b1000, 4'b0000, 4'b0000, 4'b0010, 0};
    tbl[18] = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 0};

    model_reset();
    apply_reset(5);

    for (int i = 0; i < 19; i++) begin
      run_period(tbl[i].raw);
      chk($sformatf("press[%0d]", i),   32'(acc_prs), 32'(tbl[i].prs));
      chk($sformatf("release[%0d]", i), 32'(acc_rel), 32'(tbl[i].rel));
      chk($sformatf("level[%0d]", i),   32'(lvl_a),   32'(tbl[i].lvl));
      chk($sformatf("any_cnt[%0d]", i), 32'(any_cnt), 32'(tbl[i].anyc));
      chk($sformatf("ticks[%0d]", i),   32'(tick_cnt), 32'd1);
      chk($sformatf("ss1_level[%0d]", i), 32'(lvl_b), 32'(tbl[i].raw));
    end

    // Button 3 has two qualifying samples banked; reset must discard them.
    apply_reset(3);
    chk("rst_level3", 32'(lvl_a[3]), 32'd0);
    run_period(4'b1000);
    chk("requal1_press", 32'(acc_prs), 32'd0);
    run_period(4'b1000);
    chk("requal2_press", 32'(acc_prs), 32'd0);
    chk("requal2_level", 32'(lvl_a[3]), 32'd0);
    run_period(4'b1000);
    chk("requal3_press", 32'(acc_prs), 32'b1000);
    chk("requal3_level", 32'(lvl_a), 32'b1000);

    for (int k = 0; k < 60; k++) begin
      nxt = btn_raw;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(2) == 0) nxt[b] = ~nxt[b];
      if ($urandom_range(14) == 0) apply_reset(2);
      run_period(nxt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
